// File: rtl/ice_uart_frame_rx.sv
// ice_uart_frame_rx: assembles UART bytes into [type][evid][len][payload] frames,
// buffers one frame and hands it out as a header handshake followed by a payload stream.
module ice_uart_frame_rx #(
   parameter int TIMEOUT_CYCLES = 200000,
   parameter int TO_W           = 18
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       rx_latch,
   input  logic [7:0] rx_data,
   output logic       hdr_valid,
   output logic [7:0] hdr_type,
   output logic [7:0] hdr_evid,
   output logic [7:0] hdr_len,
   input  logic       hdr_ack,
   output logic       pl_valid,
   output logic [7:0] pl_data,
   output logic       pl_last,
   input  logic       pl_ready,
   output logic       err_pulse,
   output logic [1:0] err_code,
   output logic       busy
);
   typedef enum logic [2:0] {RX_TYPE, RX_EVID, RX_LEN, RX_PAYLOAD, FRAME_DONE, DISCARD} state_t;
   state_t state;
   logic rx_latch_q;
   logic [7:0] mem [256];
   logic [7:0] r_type, r_evid, r_len, wr_ptr, rd_ptr, rd_addr;
   logic [1:0] d_stage;
   logic [TO_W-1:0] to_cnt;
   logic rx_byte, hdr_take, pl_take, buf_free, timeout, we;
   assign rx_byte  = rx_latch & ~rx_latch_q;
   assign hdr_take = hdr_valid & hdr_ack;
   assign pl_take  = pl_valid & pl_ready;
   assign pl_last  = pl_valid && rd_ptr == hdr_len - 8'd1;
   assign busy     = hdr_valid | pl_valid;
   // the final header/payload handshake frees the buffer in time for a same-cycle type byte
   assign buf_free = ~busy | (hdr_take && hdr_len == 8'd0) | (pl_take & pl_last);
   assign timeout  = !rx_byte && state != RX_TYPE && state != FRAME_DONE &&
                     to_cnt == TO_W'(TIMEOUT_CYCLES - 1);
   assign we       = rx_byte && state == RX_PAYLOAD;
   assign rd_addr  = hdr_take ? 8'd0 : (pl_take && !pl_last) ? rd_ptr + 8'd1 : rd_ptr;
   always_ff @(posedge clk)
      if (we) mem[wr_ptr] <= rx_data;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) pl_data <= '0;
      else pl_data <= mem[rd_addr];
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= RX_TYPE;
         rx_latch_q <= 1'b0;
         r_type     <= '0;
         r_evid     <= '0;
         r_len      <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         d_stage    <= '0;
         to_cnt     <= '0;
         hdr_valid  <= 1'b0;
         hdr_type   <= '0;
         hdr_evid   <= '0;
         hdr_len    <= '0;
         pl_valid   <= 1'b0;
         err_pulse  <= 1'b0;
         err_code   <= '0;
      end else begin
         rx_latch_q <= rx_latch;
         err_pulse  <= 1'b0;
         to_cnt     <= (rx_byte || timeout || state == RX_TYPE || state == FRAME_DONE) ? '0 : to_cnt + 1'b1;
         if (timeout) begin
            err_pulse <= 1'b1;
            err_code  <= 2'd1;
            state     <= RX_TYPE;
         end else if (rx_byte || state == FRAME_DONE) begin
            case (state)
               RX_TYPE: begin
                  r_type  <= rx_data;
                  d_stage <= 2'd0;
                  state   <= buf_free ? RX_EVID : DISCARD;
               end
               RX_EVID: begin
                  r_evid <= rx_data;
                  state  <= RX_LEN;
               end
               RX_LEN: begin
                  r_len  <= rx_data;
                  wr_ptr <= '0;
                  state  <= rx_data == 8'd0 ? FRAME_DONE : RX_PAYLOAD;
               end
               RX_PAYLOAD: begin
                  wr_ptr <= wr_ptr + 8'd1;
                  if (wr_ptr == r_len - 8'd1) state <= FRAME_DONE;
               end
               FRAME_DONE: begin
                  hdr_type  <= r_type;
                  hdr_evid  <= r_evid;
                  hdr_len   <= r_len;
                  hdr_valid <= 1'b1;
                  state     <= RX_TYPE;
               end
               DISCARD: begin
                  d_stage <= d_stage == 2'd2 ? d_stage : d_stage + 2'd1;
                  if (d_stage == 2'd1) begin
                     r_len  <= rx_data;
                     wr_ptr <= '0;
                  end else if (d_stage == 2'd2) wr_ptr <= wr_ptr + 8'd1;
                  if ((d_stage == 2'd1 && rx_data == 8'd0) || (d_stage == 2'd2 && wr_ptr == r_len - 8'd1)) begin
                     err_pulse <= 1'b1;
                     err_code  <= 2'd2;
                     state     <= RX_TYPE;
                  end
               end
               default: state <= RX_TYPE;
            endcase
         end
         if (hdr_take) begin
            hdr_valid <= 1'b0;
            pl_valid  <= hdr_len != 8'd0;
            rd_ptr    <= '0;
         end else if (pl_take) begin
            if (pl_last) pl_valid <= 1'b0;
            else rd_ptr <= rd_ptr + 8'd1;
         end
      end
   end
endmodule

// File: tb/tb_ice_uart_frame_rx.sv
// tb_ice_uart_frame_rx: directed and randomized frames checked against a frame-level model
// (header = first three bytes, payload = the rest, one error per discarded or stalled frame).
module tb_ice_uart_frame_rx;
   localparam int TO = 40;
   typedef logic [7:0] bq_t[$];
   logic clk = 0, reset_n = 0, rx_latch = 0, hdr_ack = 0, pl_ready = 0;
   logic [7:0] rx_data = 0;
   logic hdr_valid, pl_valid, pl_last, err_pulse, busy;
   logic [7:0] hdr_type, hdr_evid, hdr_len, pl_data;
   logic [1:0] err_code;
   int n_chk = 0, n_fail = 0, rdy_mode = 0, hdr_rises = 0, overlap = 0;
   logic [7:0] got[$];
   logic lasts[$];
   logic [1:0] errq[$];
   logic hv_q = 0;

   always #5 clk = ~clk;

   ice_uart_frame_rx #(.TIMEOUT_CYCLES(TO), .TO_W(18)) dut (
      .clk(clk), .reset_n(reset_n), .rx_latch(rx_latch), .rx_data(rx_data),
      .hdr_valid(hdr_valid), .hdr_type(hdr_type), .hdr_evid(hdr_evid), .hdr_len(hdr_len),
      .hdr_ack(hdr_ack), .pl_valid(pl_valid), .pl_data(pl_data), .pl_last(pl_last),
      .pl_ready(pl_ready), .err_pulse(err_pulse), .err_code(err_code), .busy(busy)
   );

   always @(negedge clk) begin
      if (pl_valid && pl_ready) begin
         got.push_back(pl_data);
         lasts.push_back(pl_last);
      end
      if (err_pulse) errq.push_back(err_code);
      if (hdr_valid && !hv_q) hdr_rises++;
      if (hdr_valid && pl_valid) overlap++;
      hv_q = hdr_valid;
   end

   // consumer ready pattern: 0 always, 1 toggle, 2 random, 3 driven by the main sequence
   initial begin : rdy_drv
      forever begin
         @(posedge clk);
         #1;
         if (rdy_mode == 0) pl_ready = 1;
         else if (rdy_mode == 1) pl_ready = ~pl_ready;
         else if (rdy_mode == 2) pl_ready = 1'($urandom_range(0, 1));
      end
   end

   task automatic tick(int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(logic [7:0] b);
      rx_data  = b;
      rx_latch = 1;
      tick(1 + $urandom_range(0, 1));
      rx_latch = 0;
      tick(1 + $urandom_range(0, 2));
   endtask

   task automatic send_all(input bq_t f);
      foreach (f[i]) send(f[i]);
   endtask

   task automatic wait_hdr(string tag);
      int k = 0;
      while (!hdr_valid && k < 300) begin
         tick();
         k++;
      end
      chk({tag, "_hdr_seen"}, 32'(hdr_valid), 1);
   endtask

   task automatic check_frame(string tag, input bq_t f);
      int len, k, bad;
      len = int'(f[2]);
      wait_hdr(tag);
      chk({tag, "_type"}, 32'(hdr_type), 32'(f[0]));
      chk({tag, "_evid"}, 32'(hdr_evid), 32'(f[1]));
      chk({tag, "_len"}, 32'(hdr_len), 32'(f[2]));
      chk({tag, "_pl_quiet"}, 32'(pl_valid), 0);
      got.delete();
      lasts.delete();
      hdr_ack = 1;
      tick();
      hdr_ack = 0;
      chk({tag, "_hdr_drop"}, 32'(hdr_valid), 0);
      k = 0;
      while (got.size() < len && k < 2000) begin
         tick();
         k++;
      end
      tick(3);
      chk({tag, "_pl_count"}, 32'(got.size()), 32'(len));
      bad = 0;
      for (int i = 0; i < got.size() && i < len; i++)
         if (got[i] !== f[3 + i] || lasts[i] !== (i == len - 1)) bad++;
      chk({tag, "_pl_bad"}, 32'(bad), 0);
      chk({tag, "_busy_free"}, 32'(busy), 0);
   endtask

   initial begin : main
      bq_t f;
      int r0;
      tick(3);
      chk("rst_hdr_valid", 32'(hdr_valid), 0);
      chk("rst_pl_valid", 32'(pl_valid), 0);
      chk("rst_err", {29'd0, err_pulse, err_code}, 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_hdr", {8'd0, hdr_type, hdr_evid, hdr_len}, 0);
      chk("rst_pl", {23'd0, pl_last, pl_data}, 0);
      reset_n = 1;
      tick(2);

      f = '{8'h56, 8'h00, 8'h00};
      send_all(f);
      check_frame("t1", f);

      f = '{8'h62, 8'h0c, 8'h08, 8'hf0, 8'h12, 8'h34, 8'h50, 8'hde, 8'had, 8'hbe, 8'hef};
      send_all(f);
      check_frame("t2", f);

      errq.delete();
      send(8'h62);
      send(8'h0c);
      tick(TO + 10);
      chk("t3_err_n", 32'(errq.size()), 1);
      chk("t3_err_code", 32'(errq.size() > 0 ? errq[0] : 2'd3), 1);
      chk("t3_no_hdr", 32'(hdr_valid), 0);
      f = '{8'h56, 8'h01, 8'h00};
      send_all(f);
      check_frame("t3b", f);

      send_all('{8'h56, 8'h00, 8'h00});
      wait_hdr("t4a");
      r0 = hdr_rises;
      errq.delete();
      send_all('{8'h76, 8'h01, 8'h02, 8'h00});
      tick(2);
      chk("t4_err_early", 32'(errq.size()), 0);
      send(8'h04);
      tick(2);
      chk("t4_err_n", 32'(errq.size()), 1);
      chk("t4_err_code", 32'(errq.size() > 0 ? errq[0] : 2'd3), 2);
      chk("t4_no_hdr2", 32'(hdr_rises - r0), 0);
      chk("t4_hdr_keep", {7'd0, hdr_valid, hdr_type, hdr_evid, hdr_len}, {7'd0, 1'b1, 24'h560000});
      hdr_ack = 1;
      tick();
      hdr_ack = 0;
      tick();
      chk("t4_busy_free", 32'(busy), 0);

      rdy_mode = 1;
      f = '{8'h6f, 8'h04, 8'h02, 8'h70, 8'h01};
      send_all(f);
      check_frame("t5", f);

      // next type byte lands in the same cycle as the final payload handshake
      rdy_mode = 3;
      pl_ready = 0;
      send_all('{8'h6f, 8'h05, 8'h01, 8'haa});
      wait_hdr("ts");
      got.delete();
      hdr_ack = 1;
      tick();
      hdr_ack = 0;
      tick();
      chk("ts_pl_last", {23'd0, pl_last, pl_data}, {23'd0, 1'b1, 8'haa});
      errq.delete();
      rx_data = 8'h56;
      rx_latch = 1;
      pl_ready = 1;
      tick();
      pl_ready = 0;
      tick();
      rx_latch = 0;
      tick();
      send(8'h02);
      send(8'h00);
      wait_hdr("ts2");
      chk("ts_taken", {hdr_type, hdr_evid}, 16'h5602);
      chk("ts_no_err", 32'(errq.size()), 0);
      chk("ts_got", 32'(got.size() > 0 ? got[0] : 8'h00), 32'h0aa);
      hdr_ack = 1;
      tick();
      hdr_ack = 0;
      tick();

      f = '{8'h62, 8'h0c, 8'h08, 8'hf0, 8'h12, 8'h34, 8'h50, 8'hde, 8'had, 8'hbe, 8'hef};
      send_all(f);
      wait_hdr("t6");
      hdr_ack = 1;
      tick();
      hdr_ack = 0;
      pl_ready = 1;
      tick(2);
      reset_n = 0;
      tick();
      chk("t6_rst_valid", {29'd0, hdr_valid, pl_valid, busy}, 0);
      chk("t6_rst_err", {29'd0, err_pulse, err_code}, 0);
      chk("t6_rst_hdr", {hdr_type, hdr_evid, hdr_len, pl_data}, 0);
      reset_n = 1;
      rdy_mode = 0;
      tick(2);
      f = '{8'h56, 8'h00, 8'h00};
      send_all(f);
      check_frame("t6b", f);

      rdy_mode = 2;
      for (int r = 0; r < 6; r++) begin
         int len;
         len = $urandom_range(0, 20);
         f = '{8'($urandom), 8'($urandom), 8'(len)};
         for (int i = 0; i < len; i++) f.push_back(8'($urandom));
         send_all(f);
         check_frame($sformatf("rnd%0d", r), f);
      end
      chk("no_overlap", 32'(overlap), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
